// File: rtl/stim_pkg.sv
// stim_pkg: shared state encoding and data-mode constants for the stimulus stream generator.
package stim_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;
endpackage

// File: rtl/stim_lfsr.sv
// stim_lfsr: right-shifting Galois LFSR that holds the current pseudo-random payload.
module stim_lfsr #(
  parameter int              DATA_W = 16,
  parameter logic [DATA_W-1:0] TAPS = DATA_W'(16'hB400),
  parameter logic [DATA_W-1:0] SEED = DATA_W'(16'h0001)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] value
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= SEED;
    else if (load) value <= SEED;
    else if (step) value <= (value >> 1) ^ (value[0] ? TAPS : '0);
endmodule

// File: rtl/stim_stream_gen.sv
// stim_stream_gen: programmable valid/ready beat source with incrementing or LFSR payload,
// optional idle gaps, backpressure and a done pulse at the end of each run.
module stim_stream_gen import stim_pkg::*; #(
  parameter int                DATA_W    = 16,
  parameter int                CNT_W     = 16,
  parameter int                GAP_W     = 4,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(16'hB400),
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(16'h0001)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_beats,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  beat_idx
);
  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_num, r_idx;
  logic [GAP_W-1:0]   r_gap, r_cnt;
  logic               r_mode, r_valid, r_busy, r_done;
  logic [DATA_W-1:0]  w_lfsr;
  logic               w_load, w_xfer, w_last;
  assign w_load = (r_state == IDLE) && start;
  assign w_xfer = (r_state == SEND) && out_ready;
  assign w_last = r_idx == r_num - CNT_W'(1);
  stim_lfsr #(.DATA_W(DATA_W), .TAPS(LFSR_TAPS), .SEED(LFSR_SEED)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .load(w_load), .step(w_xfer), .value(w_lfsr)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (num_beats == '0) ? FIN : SEND;
      SEND:    if (w_xfer) w_next = w_last ? FIN : (r_gap != '0 ? GAP : SEND);
      GAP:     if (r_cnt == GAP_W'(1)) w_next = SEND;
      default: w_next = IDLE;
    endcase
  end
  // Flags are computed from the next state so they change in the same cycle as the FSM.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_num   <= '0;
      r_gap   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_mode  <= MODE_INC;
    end else begin
      r_state <= w_next;
      r_valid <= w_next == SEND;
      r_busy  <= (w_next == SEND) || (w_next == GAP);
      r_done  <= w_next == FIN;
      if (w_load) begin
        r_num  <= num_beats;
        r_gap  <= gap_cycles;
        r_mode <= mode;
        r_idx  <= '0;
      end else if (w_xfer && !w_last) begin
        r_idx <= r_idx + CNT_W'(1);
        r_cnt <= r_gap;
      end else if (r_state == GAP) begin
        r_cnt <= r_cnt - GAP_W'(1);
      end
    end
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign beat_idx  = r_idx;
  assign out_data  = (r_mode == MODE_INC) ? DATA_W'(r_idx) : w_lfsr;
endmodule

// File: tb/tb_stim_stream_gen.sv
// tb_stim_stream_gen: table-driven runs with a beat scoreboard, plus reset and
// start-while-busy sequences for stim_stream_gen.
module tb_stim_stream_gen;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, out_ready = 1'b1;
  logic [15:0] num_beats = '0;
  logic [3:0]  gap_cycles = '0;
  logic        out_valid, busy, done;
  logic [15:0] out_data, beat_idx;
  int checks = 0, errors = 0;
  typedef struct {logic [15:0] data; logic [15:0] idx;} beat_t;
  typedef struct {logic m; int n; int g; int sb; int sl; int rs;} vec_t;
  beat_t q[$];
  vec_t  tbl[8];
  always #5 clk = ~clk;
  stim_stream_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats), .gap_cycles(gap_cycles),
    .mode(mode), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .beat_idx(beat_idx)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_case(input vec_t v);
    logic [15:0] lf = 16'h0001;
    int idle = 0, stalls = 0, cyc = 0;
    bit after_xfer = 1'b0, rs_fired = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      q.push_back(beat_t'{v.m ? lf : 16'(i), 16'(i)});
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    end
    start = 1'b1; num_beats = 16'(v.n); gap_cycles = 4'(v.g); mode = v.m; out_ready = 1'b1;
    tick();
    start = 1'b0;
    if (v.n == 0) begin
      check("zero_valid", 32'(out_valid), 32'd0);
    end else begin
      check("start_latency", 32'(out_valid), 32'd1);
      check("busy_run", 32'(busy), 32'd1);
      while (q.size() > 0 && cyc < 2000) begin
        cyc++;
        if (out_valid) begin
          if (after_xfer) begin
            check("gap_len", 32'(idle), 32'(v.g));
            after_xfer = 1'b0;
          end
          check("data", 32'(out_data), 32'(q[0].data));
          check("idx", 32'(beat_idx), 32'(q[0].idx));
          out_ready = !(int'(beat_idx) == v.sb && stalls < v.sl);
          if (!out_ready) stalls++;
          if (int'(beat_idx) == v.rs && !rs_fired) begin
            start = 1'b1; num_beats = 16'd2; mode = ~v.m; rs_fired = 1'b1;
          end
          if (out_ready) begin
            void'(q.pop_front());
            if (q.size() > 0) begin after_xfer = 1'b1; idle = 0; end
          end
        end else begin
          idle++;
          check("no_early_done", 32'(done), 32'd0);
        end
        tick();
        start = 1'b0; out_ready = 1'b1;
      end
      if (q.size() > 0) check("beat_timeout", 32'(q.size()), 32'd0);
      check("valid_fin", 32'(out_valid), 32'd0);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_fin", 32'(busy), 32'd0);
    // a start landing in the done cycle must not launch a run
    start = 1'b1; num_beats = 16'd3;
    tick();
    start = 1'b0;
    check("fin_start_valid", 32'(out_valid), 32'd0);
    check("fin_start_busy", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    q.delete();
  endtask
  initial begin
    tbl[0] = '{1'b0, 4, 0, -1, 0, -1};
    tbl[1] = '{1'b0, 3, 2, -1, 0, -1};
    tbl[2] = '{1'b0, 4, 0,  1, 3, -1};
    tbl[3] = '{1'b0, 0, 0, -1, 0, -1};
    tbl[4] = '{1'b0, 5, 0, -1, 0,  2};
    tbl[5] = '{1'b1, 8, 0, -1, 0, -1};
    tbl[6] = '{1'b1, 5, 1,  2, 2,  1};
    tbl[7] = '{1'b0, 3, 15, 0, 1, -1};
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(beat_idx), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) run_case(tbl[i]);
    start = 1'b1; num_beats = 16'd6; gap_cycles = '0; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && !(out_valid && beat_idx == 16'd2); c++) tick();
    check("reach_beat2", 32'(beat_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_idx", 32'(beat_idx), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("midrst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_idle_done", 32'(done), 32'd0);
      check("post_rst_idle_valid", 32'(out_valid), 32'd0);
    end
    run_case(tbl[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
